// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: shares one single-port RAM between instruction fetch
// and load/store, one access at a time with round-robin arbitration.
module mem_access_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_q,
  output logic              busy
);

  localparam int CW =
    (RD_LATENCY < 3) ? 2 : $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(RD_LATENCY);
  localparam bit LAT_ONE = (RD_LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_prio_d;
  logic              r_port_d;
  logic              r_we;
  logic              r_signed;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;

  logic        w_idle;
  logic        w_sel_d;
  logic        w_sel_i;
  logic        w_d_mis;
  logic        w_i_mis;
  logic        w_start;
  logic        w_store;
  logic        w_sample;
  logic [31:0] w_addr;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic        w_unused;

  assign w_unused = ^{d_addr[31:ADDR_W+2],
                      if_addr[31:ADDR_W+2]};

  // Arbitration: only in IDLE; gated by reset so outputs drop at once
  assign w_idle  = rst && (r_state == IDLE);
  assign w_sel_d = w_idle && d_req
                   && (!if_req || r_prio_d);
  assign w_sel_i = w_idle && if_req && !w_sel_d;

  assign w_d_mis = (d_size == 2'd3)
                 || (d_size == 2'd2 && d_addr[1:0] != 2'd0)
                 || (d_size == 2'd1 && d_addr[0]);
  assign w_i_mis = (if_addr[1:0] != 2'd0);

  assign w_start = (w_sel_d && !w_d_mis)
                 || (w_sel_i && !w_i_mis);
  assign w_addr  = w_sel_d ? d_addr : if_addr;

  assign d_gnt  = w_sel_d;
  assign d_err  = w_sel_d && w_d_mis;
  assign if_gnt = w_sel_i;
  assign if_err = w_sel_i && w_i_mis;

  assign w_store = r_port_d && r_we;
  assign busy    = (r_state != IDLE);

  assign w_sample =
    (r_state == ISSUE && !w_store && LAT_ONE)
    || (r_state == WAIT && r_cnt == LAT);

  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

  // Load alignment and sign/zero extension
  always_comb begin
    w_shift = ram_q >> {r_off, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_off[1] ? ram_q[31:16] : ram_q[15:0];
    w_ld    = ram_q;
    unique case (1'b1)
      (r_size == 2'd0):
        w_ld = {{24{r_signed & w_byte[7]}}, w_byte};
      (r_size == 2'd1):
        w_ld = {{16{r_signed & w_half[15]}}, w_half};
      default:
        w_ld = ram_q;
    endcase
  end

  // Next state and RAM strobes / response pulses
  always_comb begin
    w_next      = r_state;
    ram_addr    = '0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    ram_byteena = 4'b0000;
    ram_wdata   = '0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next = ISSUE;
      end
      ISSUE: begin
        ram_addr = r_waddr;
        if (w_store) begin
          ram_wren = 1'b1;
          w_next   = RESP;
          unique case (1'b1)
            (r_size == 2'd0): begin
              ram_byteena = 4'b0001 << r_off;
              ram_wdata   = {4{r_wdata[7:0]}};
            end
            (r_size == 2'd1): begin
              ram_byteena = r_off[1] ? 4'b1100
                                     : 4'b0011;
              ram_wdata   = {2{r_wdata[15:0]}};
            end
            default: begin
              ram_byteena = 4'b1111;
              ram_wdata   = r_wdata;
            end
          endcase
        end else begin
          ram_rden    = 1'b1;
          ram_byteena = 4'b1111;
          w_next      = LAT_ONE ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == LAT) w_next = RESP;
      end
      RESP: begin
        w_next = IDLE;
        if (r_port_d) d_rvalid  = 1'b1;
        else          if_rvalid = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Round-robin pointer moves on every grant, errors included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_prio_d <= 1'b1;
    else if (w_sel_d) r_prio_d <= 1'b0;
    else if (w_sel_i) r_prio_d <= 1'b1;
  end

  // Capture the accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_port_d <= 1'b0;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'd0;
      r_off    <= 2'd0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else if (w_start) begin
      r_port_d <= w_sel_d;
      r_we     <= w_sel_d && d_we;
      r_signed <= w_sel_d && d_signed;
      r_size   <= w_sel_d ? d_size : 2'd2;
      r_off    <= w_addr[1:0];
      r_waddr  <= w_addr[ADDR_W+1:2];
      r_wdata  <= d_wdata;
    end
  end

  // Read latency counter; the ISSUE cycle counts as 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cnt <= '0;
    else if (r_state == ISSUE)   r_cnt <= CW'(2);
    else if (r_state == WAIT)    r_cnt <= r_cnt + 1'b1;
  end

  // Response data; each port holds its last value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (w_sample) begin
      if (r_port_d) r_d_rdata  <= w_ld;
      else          r_if_rdata <= ram_q;
    end else if (r_state == ISSUE && w_store) begin
      r_d_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random checks of mem_access_ctrl
// against a transaction-level model with its own memory image.
module tb_mem_access_ctrl;

  localparam int AW  = 16;
  localparam int RDL = 2;
  localparam int NW  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_gnt, if_rvalid, if_err;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_size = 2'd0;
  logic          d_signed = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_rden, ram_wren;
  logic [3:0]    ram_byteena;
  logic [31:0]   ram_wdata, ram_q;
  logic          busy;

  logic [31:0]   ram [0:NW-1];
  logic [31:0]   mm  [0:NW-1];
  logic [AW-1:0] ra = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state
  int       m_free = 0;
  bit       m_prio_d = 1'b1;
  bit       s_rden [16];
  bit       s_wren [16];
  bit       s_iv   [16];
  bit       s_dv   [16];
  bit       s_busy [16];
  logic [AW-1:0] s_addr [16];
  logic [3:0]    s_be   [16];
  logic [31:0]   s_wd   [16];
  logic [31:0]   s_ird  [16];
  logic [31:0]   s_drd  [16];
  logic [31:0]   exp_ird = '0;
  logic [31:0]   exp_drd = '0;

  // observation logs
  int       g_cyc [$];
  bit       g_d   [$];
  int       last_rden_cyc = -1;
  int       last_rden_addr = -1;
  int       last_wren_cyc = -1;
  logic [AW-1:0] last_wren_addr = '0;
  logic [3:0]    last_wren_be = '0;
  logic [31:0]   last_wren_wd = '0;
  int       last_iv_cyc = -1;
  logic [31:0] last_iv_data = '0;
  int       last_dv_cyc = -1;
  logic [31:0] last_dv_data = '0;
  int       last_derr_cyc = -1;
  int       iv_cnt = 0;
  int       dv_cnt = 0;
  bit       saw_ig = 0;
  bit       saw_dg = 0;
  bit       hold_mode = 0;
  bit       rnd_mode = 0;

  mem_access_ctrl #(.ADDR_W(AW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err), .ram_addr(ram_addr),
    .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_byteena(ram_byteena), .ram_wdata(ram_wdata),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(
    logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // RAM with address register: q valid RDL-1 cycles after rden
  always @(posedge clk) begin
    if (ram_rden) ra <= ram_addr;
    if (ram_wren)
      ram[ram_addr] <= merge(ram[ram_addr],
                             ram_wdata, ram_byteena);
  end
  assign ram_q = ram[ra];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ld_val(
    logic [31:0] w, logic [1:0] sz, logic [1:0] off, bit sgn);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (w >> (off * 8)) & 32'hFF;
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (off[1] * 16)) & 32'hFFFF;
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic sched_read(bit isd, logic [AW-1:0] wa,
                            logic [31:0] res);
    int s1;
    int sr;
    s1 = (cyc + 1) % 16;
    sr = (cyc + RDL + 1) % 16;
    s_rden[s1] = 1;
    s_addr[s1] = wa;
    s_be[s1]   = 4'hF;
    for (int k = 1; k <= RDL + 1; k++)
      s_busy[(cyc + k) % 16] = 1;
    if (isd) begin
      s_dv[sr] = 1;  s_drd[sr] = res;
    end else begin
      s_iv[sr] = 1;  s_ird[sr] = res;
    end
    m_free = cyc + RDL + 2;
  endtask

  task automatic sched_store(logic [AW-1:0] wa,
    logic [1:0] sz, logic [1:0] off, logic [31:0] wd);
    int s1;
    int s2;
    logic [3:0]  be;
    logic [31:0] rep;
    s1 = (cyc + 1) % 16;
    s2 = (cyc + 2) % 16;
    if (sz == 2'd0) begin
      be = 4'(1 << off);
      rep = wd[7:0] * 32'h01010101;
    end else if (sz == 2'd1) begin
      be = off[1] ? 4'hC : 4'h3;
      rep = wd[15:0] * 32'h00010001;
    end else begin
      be = 4'hF;
      rep = wd;
    end
    mm[wa] = merge(mm[wa], rep, be);
    s_wren[s1] = 1;
    s_addr[s1] = wa;
    s_be[s1]   = be;
    s_wd[s1]   = rep;
    s_busy[s1] = 1;
    s_busy[s2] = 1;
    s_dv[s2]   = 1;
    s_drd[s2]  = '0;
    m_free = cyc + 3;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[17:6] = '0;
    return a;
  endfunction

  task automatic drive();
    if (saw_ig) if_req = hold_mode;
    if (saw_dg) d_req = hold_mode;
    if (rnd_mode) begin
      if (if_req) begin
        if ($urandom_range(0, 19) == 0) if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = rnd_addr();
        if ($urandom_range(0, 7) != 0) if_addr[1:0] = 2'd0;
      end
      if (d_req) begin
        if ($urandom_range(0, 19) == 0) d_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1;
        d_addr = rnd_addr();
        d_we = 1'($urandom_range(0, 1));
        d_signed = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        if ($urandom_range(0, 9) == 0) d_size = 2'd3;
        else d_size = 2'($urandom_range(0, 2));
      end
    end
  endtask

  // one clock: model + compare at negedge, then drive after posedge
  task automatic cycle();
    int slot;
    bit e_ig, e_dg, e_ie, e_de, e_iv, e_dv;
    bit e_rden, e_wren, e_busy, pick_d, mis;
    logic [AW-1:0] e_addr, wa;
    logic [3:0]    e_be;
    logic [31:0]   e_wd;
    @(negedge clk);
    cyc++;
    slot = cyc % 16;
    {e_ig, e_dg, e_ie, e_de, e_iv, e_dv} = '0;
    {e_rden, e_wren, e_busy} = '0;
    e_addr = '0; e_be = '0; e_wd = '0;
    if (!rst) begin
      m_free = 0;
      m_prio_d = 1;
      exp_ird = '0;
      exp_drd = '0;
      for (int i = 0; i < 16; i++) begin
        s_rden[i] = 0; s_wren[i] = 0; s_iv[i] = 0;
        s_dv[i] = 0;   s_busy[i] = 0;
      end
    end else begin
      e_rden = s_rden[slot];
      e_wren = s_wren[slot];
      e_busy = s_busy[slot];
      e_iv   = s_iv[slot];
      e_dv   = s_dv[slot];
      if (e_rden || e_wren) begin
        e_addr = s_addr[slot];
        e_be   = s_be[slot];
        e_wd   = s_wd[slot];
      end
      if (e_iv) exp_ird = s_ird[slot];
      if (e_dv) exp_drd = s_drd[slot];
      s_rden[slot] = 0; s_wren[slot] = 0; s_iv[slot] = 0;
      s_dv[slot] = 0;   s_busy[slot] = 0;
      if (cyc >= m_free && (if_req || d_req)) begin
        pick_d = d_req && (!if_req || m_prio_d);
        m_prio_d = !pick_d;
        if (pick_d) begin
          e_dg = 1;
          mis = (d_size == 2'd3)
             || (d_size == 2'd2 && d_addr[1:0] != 2'd0)
             || (d_size == 2'd1 && d_addr[0]);
          e_de = mis;
          wa = AW'(d_addr >> 2);
          if (!mis) begin
            if (d_we)
              sched_store(wa, d_size, d_addr[1:0], d_wdata);
            else
              sched_read(1, wa, ld_val(mm[wa], d_size,
                                       d_addr[1:0], d_signed));
          end
        end else begin
          e_ig = 1;
          mis = (if_addr[1:0] != 2'd0);
          e_ie = mis;
          wa = AW'(if_addr >> 2);
          if (!mis) sched_read(0, wa, mm[wa]);
        end
      end
    end
    chk("if_gnt", if_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("if_err", if_err, e_ie);
    chk("d_err", d_err, e_de);
    chk("if_rvalid", if_rvalid, e_iv);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("if_rdata", if_rdata, exp_ird);
    chk("d_rdata", d_rdata, exp_drd);
    chk("ram_rden", ram_rden, e_rden);
    chk("ram_wren", ram_wren, e_wren);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_byteena", ram_byteena, e_be);
    if (e_wren) chk("ram_wdata", ram_wdata, e_wd);
    chk("busy", busy, e_busy);
    saw_ig = if_gnt;
    saw_dg = d_gnt;
    if (if_gnt) begin g_cyc.push_back(cyc); g_d.push_back(0); end
    if (d_gnt)  begin g_cyc.push_back(cyc); g_d.push_back(1); end
    if (d_err) last_derr_cyc = cyc;
    if (ram_rden) begin
      last_rden_cyc = cyc; last_rden_addr = int'(ram_addr);
    end
    if (ram_wren) begin
      last_wren_cyc = cyc;     last_wren_addr = ram_addr;
      last_wren_be = ram_byteena; last_wren_wd = ram_wdata;
    end
    if (if_rvalid) begin
      iv_cnt++; last_iv_cyc = cyc; last_iv_data = if_rdata;
    end
    if (d_rvalid) begin
      dv_cnt++; last_dv_cyc = cyc; last_dv_data = d_rdata;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      cycle();
      if (!if_req && !d_req && !busy) done = 1;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout %s: got busy expected idle", nm);
    end
  endtask

  task automatic do_reset();
    rst = 0;
    if_req = 0;
    d_req = 0;
    repeat (2) cycle();
    rst = 1;
    cycle();
  endtask

  task automatic chk_all_zero();
    chk("rz_if_gnt", if_gnt, 0);
    chk("rz_if_rvalid", if_rvalid, 0);
    chk("rz_if_rdata", if_rdata, 0);
    chk("rz_if_err", if_err, 0);
    chk("rz_d_gnt", d_gnt, 0);
    chk("rz_d_rvalid", d_rvalid, 0);
    chk("rz_d_rdata", d_rdata, 0);
    chk("rz_d_err", d_err, 0);
    chk("rz_ram_addr", ram_addr, 0);
    chk("rz_ram_rden", ram_rden, 0);
    chk("rz_ram_wren", ram_wren, 0);
    chk("rz_byteena", ram_byteena, 0);
    chk("rz_wdata", ram_wdata, 0);
    chk("rz_busy", busy, 0);
  endtask

  task automatic d_op(bit we, logic [1:0] sz, bit sg,
                      logic [31:0] a, logic [31:0] wd);
    d_we = we; d_size = sz; d_signed = sg;
    d_addr = a; d_wdata = wd; d_req = 1;
    run_until_idle("d_op");
  endtask

  initial begin
    int t;
    int base;
    int ivb;
    int dvb;
    bit ok;
    for (int i = 0; i < NW; i++) begin
      ram[i] = $urandom;
      mm[i] = ram[i];
    end
    ram[4] = 32'h00500093;
    mm[4]  = 32'h00500093;

    repeat (2) cycle();
    #1;
    chk_all_zero();
    rst = 1;
    cycle();

    // fetch from 0x10
    if_addr = 32'h10;
    if_req = 1;
    run_until_idle("fetch");
    t = g_cyc[g_cyc.size() - 1];
    chk("fetch_port", 32'(g_d[g_d.size() - 1]), 0);
    chk("fetch_rden_cyc", last_rden_cyc, t + 1);
    chk("fetch_rden_addr", last_rden_addr, 4);
    chk("fetch_rv_cyc", last_iv_cyc, t + 3);
    chk("fetch_rdata", last_iv_data, 32'h00500093);

    // byte store to 0x13
    d_op(1, 2'd0, 0, 32'h13, 32'h000000AB);
    t = g_cyc[g_cyc.size() - 1];
    chk("sb_wren_cyc", last_wren_cyc, t + 1);
    chk("sb_addr", last_wren_addr, 4);
    chk("sb_be", last_wren_be, 4'b1000);
    chk("sb_wdata", last_wren_wd, 32'hABABABAB);
    chk("sb_rv_cyc", last_dv_cyc, t + 2);
    chk("sb_rdata", last_dv_data, 0);

    // loads from word 4
    ram[4] = 32'h80017FFF;
    mm[4]  = 32'h80017FFF;
    d_op(0, 2'd1, 1, 32'h12, 0);
    chk("lh_signed", last_dv_data, 32'hFFFF8001);
    d_op(0, 2'd1, 0, 32'h12, 0);
    chk("lh_unsigned", last_dv_data, 32'h00008001);
    d_op(0, 2'd0, 1, 32'h11, 0);
    chk("lb_signed", last_dv_data, 32'h0000007F);

    // contention, both held
    do_reset();
    base = g_cyc.size();
    hold_mode = 1;
    if_addr = 32'h20;
    d_we = 0; d_size = 2'd2; d_signed = 0;
    d_addr = 32'h24;
    if_req = 1; d_req = 1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      if (g_cyc.size() >= base + 4) ok = 1;
    end
    hold_mode = 0;
    if_req = 0; d_req = 0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL timeout rr: got %0d grants expected 4",
               g_cyc.size() - base);
    end else begin
      for (int k = 0; k < 4; k++)
        chk("rr_order", 32'(g_d[base + k]),
            (k % 2 == 0) ? 1 : 0);
      for (int k = 1; k < 4; k++)
        chk("rr_spacing",
            g_cyc[base + k] - g_cyc[base + k - 1], RDL + 2);
    end
    run_until_idle("rr_drain");

    // misaligned word load with a fetch pending
    do_reset();
    base = g_cyc.size();
    dvb = dv_cnt;
    if_addr = 32'h10; if_req = 1;
    d_we = 0; d_size = 2'd2; d_addr = 32'h06; d_req = 1;
    run_until_idle("misaligned");
    if (g_cyc.size() >= base + 2) begin
      chk("mis_first_d", 32'(g_d[base]), 1);
      chk("mis_err_cyc", last_derr_cyc, g_cyc[base]);
      chk("mis_next_i", 32'(g_d[base + 1]), 0);
      chk("mis_i_gap", g_cyc[base + 1] - g_cyc[base], 1);
    end else begin
      n_chk++; n_fail++;
      $display("FAIL mis_grants: got %0d expected 2",
               g_cyc.size() - base);
    end
    chk("mis_no_dvalid", dv_cnt - dvb, 0);

    // reset during WAIT of a fetch
    base = g_cyc.size();
    if_addr = 32'h10; if_req = 1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      if (g_cyc.size() > base) ok = 1;
    end
    chk("rw_granted", 32'(ok), 1);
    cycle();
    ivb = iv_cnt;
    rst = 0;
    #1;
    chk_all_zero();
    if_req = 0;
    repeat (3) cycle();
    rst = 1;
    repeat (4) cycle();
    chk("rw_no_rvalid", iv_cnt - ivb, 0);
    if_addr = 32'h10; if_req = 1;
    run_until_idle("refetch");
    chk("rw_refetch", last_iv_data, 32'h80017FFF);

    // random traffic
    rnd_mode = 1;
    repeat (4000) cycle();
    rnd_mode = 0;
    if_req = 0; d_req = 0;
    run_until_idle("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Shares the single-port system RAM between the instruction-fetch requester and the load/store requester of the multi-cycle core. It arbitrates between them round-robin and performs one access at a time. It generates byte enables and write-lane replication from access size and address. It aligns and sign- or zero-extends load data, and it flags misaligned accesses without touching RAM.

Parameters:
ADDR_W, 16, RAM word-address width; byte address bits [ADDR_W+1:2] select the word, and higher bits are ignored (wrap).
RD_LATENCY, 2, cycles from the cycle ram_rden is asserted to the cycle ram_q is valid (minimum 1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_gnt
if_addr  in  32  fetch byte address
if_gnt  out  1  one-cycle accept pulse
if_rvalid  out  1  one-cycle read-data-valid pulse
if_rdata  out  32  fetched word; held until the next if_rvalid
if_err  out  1  one-cycle misaligned pulse, coincident with if_gnt
d_req  in  1  data request; held high until d_gnt
d_we  in  1  1 = store, 0 = load
d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
d_signed  in  1  load sign-extend enable
d_addr  in  32  data byte address
d_wdata  in  32  store data, LSB-aligned
d_gnt  out  1  one-cycle accept pulse
d_rvalid  out  1  one-cycle completion pulse (load data or store ack)
d_rdata  out  32  aligned, extended load data; 0 on store ack
d_err  out  1  one-cycle misaligned/illegal pulse, coincident with d_gnt
ram_addr  out  ADDR_W  RAM word address
ram_rden  out  1  RAM read enable
ram_wren  out  1  RAM write enable
ram_byteena  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_q  in  32  RAM read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: all outputs 0 except ram_byteena = 0000. State goes to IDLE and the round-robin pointer favours data. Reset mid-access abandons the access; no rvalid is issued, and the requester re-issues its request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one requester has req high, grant it.
  - If both are high, grant the port not granted last; the first contention after reset goes to data.
  - The gnt pulse occurs in IDLE cycle T, and the request fields are registered at the end of T.
  - Misaligned requests: a word access with addr[1:0]≠0, a half access with addr[0]=1, d_size=3, or a fetch with if_addr[1:0]≠0.
    - gnt and err pulse together in T.
    - No RAM access occurs, the state stays IDLE, and no rvalid is issued.
    - The error still updates the round-robin pointer.
- ISSUE (cycle T+1): drive ram_addr = addr[ADDR_W+1:2] for exactly this cycle. Then:
  - Load or fetch: ram_rden=1, byteena=1111, go to WAIT.
  - Store: ram_wren=1, go to RESP.
    - byte: byteena = 0001 shifted left by addr[1:0]; wdata = 4 copies of wdata[7:0].
    - half: byteena = 0011 (addr[1]=0) or 1100; wdata = 2 copies of wdata[15:0].
    - word: byteena = 1111; wdata unchanged.
- WAIT:
  - A counter runs from 1 and ram_q is sampled when it reaches RD_LATENCY.
  - The sample lands at the end of cycle T+RD_LATENCY, then the FSM goes to RESP.
  - RAM strobes are 0 throughout WAIT.
- RESP:
  - One cycle; the rvalid of the granted port pulses.
  - Load, T+RD_LATENCY+1: byte selects lane addr[1:0]; half selects lane addr[1]. The result is sign-extended if d_signed, else zero-extended.
  - Fetch: the full word goes to if_rdata.
  - Store, T+2: d_rvalid pulses with d_rdata = 0.
  - Next state is IDLE, so the earliest next gnt is the cycle after RESP.
- Request handling: req is ignored while busy. A request dropped before gnt is never serviced. The round-robin pointer updates only on gnt.
- Output holding: rdata holds its last value between pulses. The other port's outputs are unaffected.

Test Plan:
- Fetch only, RD_LATENCY=2, if_addr=0x10, RAM word 4 = 0x00500093:
  - if_gnt at T; ram_rden=1 and ram_addr=4 at T+1 only.
  - if_rvalid at T+3 with if_rdata=0x00500093; busy high T+1..T+3.
- Store byte, d_addr=0x13, d_wdata=0x000000AB:
  - T+1: ram_wren=1, ram_addr=4, byteena=1000, ram_wdata=0xABABABAB.
  - d_rvalid at T+2 with d_rdata=0.
- Load half from d_addr=0x12, word at index 4 = 0x80017FFF:
  - d_signed=1 → d_rdata=0xFFFF8001.
  - d_signed=0 → d_rdata=0x00008001.
  - Load byte at 0x11 signed → 0x0000007F.
- if_req and d_req both held continuously:
  - Grants alternate D, I, D, I.
  - Each grant is spaced RD_LATENCY+2 cycles apart.
  - No overlapping RAM strobes.
- Word load at d_addr=0x06:
  - d_gnt and d_err in the same cycle.
  - ram_rden/ram_wren stay 0 and d_rvalid never pulses.
  - The next pending if_req is granted the following cycle.
- Drop rst during WAIT of a fetch:
  - All outputs are 0 immediately (asynchronously) and no if_rvalid is issued.
  - After release, a re-issued if_req completes normally with correct data.
